// File: rtl/conv1d_mac_ctrl.sv
// Operand-feed and enable sequencer for an external 3-stage saturating MAC.
// Loads M taps then N samples, then emits valid-mode convolution outputs y[0..N-M].
module conv1d_mac_ctrl #(
    parameter int T = 14,
    parameter int N = 16,
    parameter int M = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [T-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [T-1:0]     mac_a,
    output logic [T-1:0]     mac_b,
    output logic             mac_en_mult,
    output logic             mac_en_preg,
    output logic             mac_en_acc,
    output logic             mac_clear_acc,
    output logic             mac_clear_pipe,
    input  logic [2*T-1:0]   mac_f,
    output logic [2*T-1:0]   m_data,
    output logic             m_valid,
    input  logic             m_ready
);

    localparam int FW = (M > 1) ? $clog2(M) : 1;
    localparam int XW = (N > 1) ? $clog2(N) : 1;
    localparam logic [XW-1:0] F_LAST = XW'(M - 1);
    localparam logic [XW-1:0] X_LAST = XW'(N - 1);
    localparam logic [XW-1:0] K_LAST = XW'(N - M);
    localparam logic [FW-1:0] J_LAST = FW'(M - 1);

    typedef enum logic [2:0] {
        ST_LOAD_F,
        ST_LOAD_X,
        ST_CLEAR,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUT
    } state_t;

    state_t         state_q;
    logic [XW-1:0]  cnt_q;
    logic [XW-1:0]  k_q;
    logic [FW-1:0]  j_q;
    logic           drain_q;
    logic           s_ready_q;
    logic           m_valid_q;
    logic           en_mult_q;
    logic           en_preg_q;
    logic           en_acc_q;
    logic           clear_acc_q;
    logic           clear_pipe_q;
    logic [T-1:0]   mac_a_q;
    logic [T-1:0]   mac_b_q;

    logic [T-1:0]   f_mem [M];
    logic [T-1:0]   x_mem [N];

    logic           s_fire;
    logic [FW-1:0]  rd_j_d;
    logic [XW-1:0]  rd_x_d;

    // s_ready is masked by reset so no word is taken during a reset cycle
    assign s_ready = s_ready_q & reset;
    assign s_fire  = s_valid & s_ready;

    always_ff @(posedge clk) begin
        if (s_fire && (state_q == ST_LOAD_F)) begin
            f_mem[cnt_q[FW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (s_fire && (state_q == ST_LOAD_X)) begin
            x_mem[cnt_q] <= s_data;
        end
    end

    // Index of the operand pair to be issued in the following cycle
    always_comb begin
        rd_j_d = '0;
        if (state_q == ST_ISSUE) begin
            rd_j_d = j_q + FW'(1);
        end
        rd_x_d = k_q + XW'(rd_j_d);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_LOAD_F;
            cnt_q        <= '0;
            k_q          <= '0;
            j_q          <= '0;
            drain_q      <= 1'b0;
            s_ready_q    <= 1'b1;
            m_valid_q    <= 1'b0;
            en_mult_q    <= 1'b0;
            en_preg_q    <= 1'b0;
            en_acc_q     <= 1'b0;
            clear_acc_q  <= 1'b1;
            clear_pipe_q <= 1'b1;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
        end else begin
            en_preg_q <= en_mult_q;
            en_acc_q  <= en_preg_q;
            en_mult_q <= 1'b0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;

            case (state_q)
                ST_LOAD_F: begin
                    if (s_fire) begin
                        if (cnt_q == F_LAST) begin
                            state_q <= ST_LOAD_X;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + XW'(1);
                        end
                    end
                end

                ST_LOAD_X: begin
                    if (s_fire) begin
                        if (cnt_q == X_LAST) begin
                            state_q      <= ST_CLEAR;
                            cnt_q        <= '0;
                            k_q          <= '0;
                            s_ready_q    <= 1'b0;
                            clear_pipe_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + XW'(1);
                        end
                    end
                end

                ST_CLEAR: begin
                    state_q     <= ST_ISSUE;
                    j_q         <= '0;
                    clear_acc_q <= 1'b0;
                    en_mult_q   <= 1'b1;
                    mac_a_q     <= x_mem[rd_x_d];
                    mac_b_q     <= f_mem[rd_j_d];
                end

                ST_ISSUE: begin
                    if (j_q == J_LAST) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 1'b0;
                    end else begin
                        j_q       <= j_q + FW'(1);
                        en_mult_q <= 1'b1;
                        mac_a_q   <= x_mem[rd_x_d];
                        mac_b_q   <= f_mem[rd_j_d];
                    end
                end

                // Two cycles let the last product pass the pipe register and accumulate
                ST_DRAIN: begin
                    if (drain_q) begin
                        state_q   <= ST_OUT;
                        m_valid_q <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end

                ST_OUT: begin
                    if (m_ready) begin
                        m_valid_q   <= 1'b0;
                        clear_acc_q <= 1'b1;
                        if (k_q == K_LAST) begin
                            state_q      <= ST_LOAD_F;
                            cnt_q        <= '0;
                            s_ready_q    <= 1'b1;
                            clear_pipe_q <= 1'b1;
                        end else begin
                            state_q <= ST_CLEAR;
                            k_q     <= k_q + XW'(1);
                        end
                    end
                end

                default: begin
                    state_q <= ST_LOAD_F;
                end
            endcase
        end
    end

    assign mac_a          = mac_a_q;
    assign mac_b          = mac_b_q;
    assign mac_en_mult    = en_mult_q;
    assign mac_en_preg    = en_preg_q;
    assign mac_en_acc     = en_acc_q;
    assign mac_clear_acc  = clear_acc_q;
    assign mac_clear_pipe = clear_pipe_q;
    assign m_valid        = m_valid_q;
    // The MAC already saturates, and is idle while OUT waits, so its value is forwarded as-is
    assign m_data         = mac_f;

endmodule
